// File: rtl/rtc_pkg.sv
// Shared state encoding, field limits and BCD / 12-hour helpers for the RTC core.
package rtc_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    SET_AH = 3'd4,
    SET_AM = 3'd5
  } rtc_state_t;

  localparam logic [5:0] HOUR_MAX   = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Returns {pm, hour12}; hour 0 shows as 12 AM, hour 12 as 12 PM.
  function automatic logic [6:0] to24_12(input logic [5:0] h);
    if (h == 6'd0)       return {1'b0, 6'd12};
    else if (h < 6'd12)  return {1'b0, h};
    else if (h == 6'd12) return {1'b1, 6'd12};
    else                 return {1'b1, h - 6'd12};
  endfunction

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] vmax,
                                           input logic up);
    if (up) return (v >= vmax) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? vmax : v - 6'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low raw key: synchronises the input and emits a single-cycle
// press pulse once the key has been stably low for DEB_CNT cycles.
module key_debounce #(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CNT - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;

  // cnt counts down while the synchronised level differs from the accepted one;
  // any bounce back reloads it, so only an unbroken run is accepted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= RELOAD;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        stable <= sync[1];
        cnt    <= RELOAD;
        press  <= ~sync[1];
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_set_core.sv
// Timekeeping core: seconds prescaler, HH:MM:SS counters, key-driven set FSM, 12/24 h display
// and blink mask. Defining RTC_ALARM_EN adds alarm set states and drives the Alarm output.
//
// state  | meaning
// RUN    | time advances on prescaler tick, inc/dec ignored
// SET_H  | editing hours, time frozen
// SET_M  | editing minutes, time frozen
// SET_S  | editing seconds, time frozen
// SET_AH | editing alarm hours (RTC_ALARM_EN only)
// SET_AM | editing alarm minutes (RTC_ALARM_EN only)
module rtc_set_core
  import rtc_pkg::*;
#(
  parameter int MCNT_S     = 50_000_000,
  parameter int DEB_CNT    = 1_000_000,
  parameter bit MODE24_RST = 1'b1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  Key,
  output logic [23:0] Disp_bcd,
  output logic [5:0]  Blink,
  output logic        Pm,
  output logic        Set_mode,
  output logic        Alarm
);

  localparam int PW = (MCNT_S > 1) ? $clog2(MCNT_S) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(MCNT_S - 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_DIV - 1);

  logic [3:0]    press;
  logic          p_mode, p_inc, p_dec, p_tog;
  rtc_state_t    state, state_adv;
  logic [PW-1:0] presc;
  logic [5:0]    hh, mm, ss;
  logic [5:0]    hh_nx, mm_nx, ss_nx;
  logic          mode24;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          tick, adj;
  logic [5:0]    show_h, show_m, show_s, disp_h;
  logic [6:0]    hour12;
  logic          pm_nx;
  logic [5:0]    blink_mask;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .key_n  (Key[i]),
      .press  (press[i])
    );
  end

  assign p_mode = press[3];
  assign p_inc  = press[2];
  assign p_dec  = press[1];
  assign p_tog  = press[0];

  always_comb begin
    tick  = (state == RUN) && (presc == PRESC_TC);
    adj   = (p_inc ^ p_dec) && !p_mode;
    ss_nx = ss;
    mm_nx = mm;
    hh_nx = hh;
    if (tick) begin
      ss_nx = wrap_step(ss, MINSEC_MAX, 1'b1);
      if (ss == MINSEC_MAX) begin
        mm_nx = wrap_step(mm, MINSEC_MAX, 1'b1);
        if (mm == MINSEC_MAX) hh_nx = wrap_step(hh, HOUR_MAX, 1'b1);
      end
    end
    case (state)
      RUN:     state_adv = SET_H;
      SET_H:   state_adv = SET_M;
      SET_M:   state_adv = SET_S;
`ifdef RTC_ALARM_EN
      SET_S:   state_adv = SET_AH;
      SET_AH:  state_adv = SET_AM;
`endif
      default: state_adv = RUN;
    endcase
  end

  // Prescaler is held at 0 outside RUN so the first second after leaving set mode is full.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= RUN;
      presc       <= '0;
      hh          <= '0;
      mm          <= '0;
      ss          <= '0;
      mode24      <= MODE24_RST;
      blink_cnt   <= BLINK_RELOAD;
      blink_phase <= 1'b0;
    end else begin
      if (p_tog)  mode24 <= ~mode24;
      if (p_mode) state  <= state_adv;
      presc <= (state != RUN || tick) ? '0 : presc + 1'b1;
      hh <= hh_nx;
      mm <= mm_nx;
      ss <= ss_nx;
      if (adj) begin
        case (state)
          SET_H:   hh <= wrap_step(hh, HOUR_MAX, p_inc);
          SET_M:   mm <= wrap_step(mm, MINSEC_MAX, p_inc);
          SET_S:   ss <= wrap_step(ss, MINSEC_MAX, p_inc);
          default: ;
        endcase
      end
      if (p_mode) begin
        blink_cnt   <= BLINK_RELOAD;
        blink_phase <= 1'b0;
      end else if (blink_cnt == '0) begin
        blink_cnt   <= BLINK_RELOAD;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [5:0] al_hh, al_mm, al_cnt;
  logic       al_on;
  logic       any_press;

  assign any_press = |press;

  // Alarm fires on the tick that lands on hh:mm:00 and lasts 60 ticks unless a key cancels it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      al_hh  <= '0;
      al_mm  <= '0;
      al_cnt <= '0;
      al_on  <= 1'b0;
    end else begin
      if (adj && state == SET_AH) al_hh <= wrap_step(al_hh, HOUR_MAX, p_inc);
      if (adj && state == SET_AM) al_mm <= wrap_step(al_mm, MINSEC_MAX, p_inc);
      if (tick && hh_nx == al_hh && mm_nx == al_mm && ss_nx == 6'd0) begin
        al_on  <= 1'b1;
        al_cnt <= 6'd59;
      end else if (al_on && any_press) begin
        al_on <= 1'b0;
      end else if (al_on && tick) begin
        if (al_cnt == '0) al_on <= 1'b0;
        else              al_cnt <= al_cnt - 1'b1;
      end
    end
  end

  assign Alarm = al_on;
`else
  assign Alarm = 1'b0;
`endif

  always_comb begin
    show_h = hh;
    show_m = mm;
    show_s = ss;
`ifdef RTC_ALARM_EN
    if (state == SET_AH || state == SET_AM) begin
      show_h = al_hh;
      show_m = al_mm;
      show_s = 6'd0;
    end
`endif
    hour12 = to24_12(show_h);
    if (mode24) begin
      disp_h = show_h;
      pm_nx  = 1'b0;
    end else begin
      disp_h = hour12[5:0];
      pm_nx  = hour12[6];
    end
    case (state)
      SET_H, SET_AH: blink_mask = 6'b110000;
      SET_M, SET_AM: blink_mask = 6'b001100;
      SET_S:         blink_mask = 6'b000011;
      default:       blink_mask = 6'b000000;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Disp_bcd <= MODE24_RST ? 24'h000000 : 24'h120000;
      Blink    <= '0;
      Pm       <= 1'b0;
      Set_mode <= 1'b0;
    end else begin
      Disp_bcd <= {bin2bcd(disp_h), bin2bcd(show_m), bin2bcd(show_s)};
      Blink    <= blink_mask & {6{blink_phase}};
      Pm       <= pm_nx;
      Set_mode <= (state != RUN);
    end
  end

endmodule

// File: tb/tb_rtc_set_core.sv
// Directed bench for rtc_set_core with short prescaler, debounce and blink periods.
`timescale 1ns/1ps
module tb_rtc_set_core;

  localparam logic [3:0] K_MODE = 4'b1000;
  localparam logic [3:0] K_INC  = 4'b0100;
  localparam logic [3:0] K_DEC  = 4'b0010;
  localparam logic [3:0] K_TOG  = 4'b0001;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  Key = 4'hF;
  logic [23:0] Disp_bcd;
  logic [5:0]  Blink;
  logic        Pm, Set_mode, Alarm;
  int          n_chk = 0;
  int          n_bad = 0;
  bit          ok;

  always #5 Clk = ~Clk;

  rtc_set_core #(
    .MCNT_S(5), .DEB_CNT(4), .MODE24_RST(1'b1), .BLINK_DIV(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Key(Key), .Disp_bcd(Disp_bcd),
    .Blink(Blink), .Pm(Pm), .Set_mode(Set_mode), .Alarm(Alarm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press(input logic [3:0] k);
    Key = Key & ~k;
    cycles(8);
    Key = Key | k;
    cycles(8);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Key     = 4'hF;
    cycles(3);
    Reset_n = 1'b1;
  endtask

  // Holds mode low and returns at the first sample where Set_mode has dropped.
  task automatic mode_to_run(output bit done);
    done   = 1'b0;
    Key[3] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (!Set_mode) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // reset values
    cycles(3);
    chk("rst_disp", Disp_bcd, 24'h000000);
    chk("rst_blink", Blink, 6'b0);
    chk("rst_pm", Pm, 1'b0);
    chk("rst_set", Set_mode, 1'b0);
    chk("rst_alarm", Alarm, 1'b0);
    Reset_n = 1'b1;

    // 1: free run, 59 s then first minute carry
    cycles(298);
    chk("run_59s", Disp_bcd, 24'h000059);
    cycles(4);
    chk("run_1min", Disp_bcd, 24'h000100);

    // 2: enter SET_H right after reset (one tick lands first -> 00:00:01)
    do_reset();
    press(K_MODE);
    cycles(4);
    chk("blink_h_on", Blink, 6'b110000);
    cycles(8);
    chk("blink_h_off", Blink, 6'b000000);
    cycles(8);
    chk("blink_h_on2", Blink, 6'b110000);
    chk("set_mode_on", Set_mode, 1'b1);
    press(K_DEC);
    chk("hour_dec_wrap", Disp_bcd, 24'h230001);
    cycles(100);
    chk("frozen", Disp_bcd, 24'h230001);
    chk("still_set", Set_mode, 1'b1);

    // 3: minutes wrap without hour carry, then exit and midnight rollover
    press(K_MODE);
    cycles(4);
    chk("blink_m_on", Blink, 6'b001100);
    press(K_DEC);
    chk("min_dec_wrap", Disp_bcd, 24'h235901);
    press(K_INC);
    chk("min_inc_wrap", Disp_bcd, 24'h230001);
    press(K_DEC);
    press(K_MODE);
    press(K_DEC);
    chk("sec_dec", Disp_bcd, 24'h235900);
    press(K_DEC);
    chk("sec_dec_wrap", Disp_bcd, 24'h235959);
`ifdef RTC_ALARM_EN
    press(K_MODE);
    press(K_MODE);
`endif
    mode_to_run(ok);
    chk("run_entry", ok, 1'b1);
    chk("exit_disp", Disp_bcd, 24'h235959);
    cycles(4);
    chk("pre_tick", Disp_bcd, 24'h235959);
    cycles(1);
    chk("rollover", Disp_bcd, 24'h000000);
`ifndef RTC_ALARM_EN
    chk("no_alarm", Alarm, 1'b0);
`endif
    Key[3] = 1'b1;
    cycles(8);

    // 4: 12 h display of set time
    do_reset();
    press(K_MODE);
    press(K_TOG);
    chk("h12_midnight", Disp_bcd, 24'h120001);
    chk("h12_midnight_pm", Pm, 1'b0);
    repeat (11) press(K_DEC);
    chk("h12_13", Disp_bcd, 24'h010001);
    chk("h12_13_pm", Pm, 1'b1);
    press(K_DEC);
    chk("h12_noon", Disp_bcd, 24'h120001);
    chk("h12_noon_pm", Pm, 1'b1);
    press(K_DEC);
    chk("h12_11", Disp_bcd, 24'h110001);
    chk("h12_11_pm", Pm, 1'b0);
    press(K_INC);
    press(K_INC);
    press(K_MODE | K_INC);
    chk("mode_beats_inc", Disp_bcd, 24'h010001);
    press(K_INC);
    chk("now_in_min", Disp_bcd, 24'h010101);
    repeat (4) press(K_INC);
    chk("min_05", Disp_bcd, 24'h010501);
    press(K_MODE);
    press(K_DEC);
    chk("t130500_12h", Disp_bcd, 24'h010500);
    chk("t130500_pm", Pm, 1'b1);
    press(K_TOG);
    chk("t130500_24h", Disp_bcd, 24'h130500);
    chk("pm_24h", Pm, 1'b0);

    // 5: glitch and simultaneous inc+dec
    Key[2] = 1'b0;
    cycles(3);
    Key[2] = 1'b1;
    cycles(10);
    chk("glitch", Disp_bcd, 24'h130500);
    press(K_INC | K_DEC);
    chk("inc_dec_both", Disp_bcd, 24'h130500);
    chk("still_set_s", Set_mode, 1'b1);

`ifdef RTC_ALARM_EN
    // 6: alarm 00:01 fires when time reaches 00:01:00 and a key press cancels it
    do_reset();
    repeat (4) press(K_MODE);
    chk("al_show", Disp_bcd, 24'h000000);
    press(K_MODE);
    press(K_INC);
    chk("al_set", Disp_bcd, 24'h000100);
    mode_to_run(ok);
    chk("al_run_entry", ok, 1'b1);
    chk("al_time", Disp_bcd, 24'h000001);
    chk("al_idle", Alarm, 1'b0);
    cycles(292);
    chk("al_before", Alarm, 1'b0);
    cycles(3);
    chk("al_fire", Alarm, 1'b1);
    chk("al_fire_disp", Disp_bcd, 24'h000100);
    Key[3] = 1'b1;
    cycles(8);
    chk("al_hold", Alarm, 1'b1);
    press(K_INC);
    chk("al_cancel", Alarm, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
